// File: rtl/adc_serial_rx.sv
// ADC serial read port: on a drdy_n fall, drive SCLK/rfs_n and shift in one MSB-first sample.
// drdy_n fall -> rfs_n low in 3 clks; sample_valid after 2*WORD_WIDTH*CLK_DIV more; unaccepted samples are overwritten with an overrun pulse.
module adc_serial_rx #(
  parameter int CLK_DIV    = 4,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  drdy_n,
  input  logic                  sdata_in,
  output logic                  sclk,
  output logic                  rfs_n,
  output logic [WORD_WIDTH-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WORD_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH);

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    drdy_s1;
  logic                    drdy_s2;
  logic                    drdy_prev;
  logic                    drdy_fall;
  logic [DIV_W-1:0]        div_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [WORD_WIDTH-1:0]   shift_reg;
  logic                    start;
  logic                    div_tc;
  logic                    shift_en;
  logic                    done;
  logic                    accept;

  // Synchronizer resets high so a low drdy_n at reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drdy_s1   <= 1'b1;
      drdy_s2   <= 1'b1;
      drdy_prev <= 1'b1;
    end else begin
      drdy_s1   <= drdy_n;
      drdy_s2   <= drdy_s1;
      drdy_prev <= drdy_s2;
    end
  end

  assign drdy_fall = drdy_prev & ~drdy_s2;
  assign accept    = sample_valid & sample_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    div_tc    = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (drdy_fall && enable) begin
          start     = 1'b1;
          state_nxt = FRAME;
        end
      end
      FRAME: begin
        div_tc = (div_cnt == DIV_LAST);
        // sclk high at terminal count means this edge drives it low: sample the ADC bit.
        if (div_tc && sclk) begin
          shift_en = 1'b1;
        end
        if (div_tc && !sclk && (bit_cnt == CNT_LAST)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk      <= 1'b1;
      rfs_n     <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (start) begin
      rfs_n   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == FRAME) begin
      if (div_tc) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {shift_reg[WORD_WIDTH-2:0], sdata_in};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (done) begin
        rfs_n <= 1'b1;
      end
    end
  end

  // A completing frame always wins over an accept on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= done & sample_valid & ~sample_ready;
      if (done) begin
        sample       <= shift_reg;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Serial read-port receiver for the fetal-ECG front-end ADC; the companion of the control-word writer, which shares the same SCLK/frame-sync serial bus style.
- Waits for the ADC data-ready strobe, generates SCLK and the active-low receive frame sync, and shifts in one WORD_WIDTH-bit sample MSB first.
- Presents each sample on a valid/ready interface to the downstream filtering chain.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period; legal range is 2 or more.
- WORD_WIDTH, 16, bits per ADC sample frame.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when high, a new frame may start.
- drdy_n  input  1  ADC data-ready, active low; asynchronous to clk.
- sdata_in  input  1  ADC serial data out; the ADC updates it on SCLK rising edges.
- sclk  output  1  generated serial clock; idles high.
- rfs_n  output  1  receive frame sync, active low; low for the whole frame.
- sample  output  WORD_WIDTH  last received sample, MSB = first bit received.
- sample_valid  output  1  sample is held and unaccepted.
- sample_ready  input  1  downstream accepts on clk edge when sample_valid and sample_ready are both high.
- overrun  output  1  one-cycle pulse when an unaccepted sample is overwritten.

Behaviour:
- Reset values:
  - sclk=1, rfs_n=1, sample=0, sample_valid=0, overrun=0.
  - Internal: state=IDLE, divider=0, bit counter=0, shift register=0, synchronizer flops=1.
  - Reset applies immediately, including mid-frame; the partial frame is discarded and no sample_valid is produced.
- drdy_n synchronizer and trigger:
  - drdy_n passes through a 2-flop synchronizer, then a falling-edge detector (previous=1, current=0).
  - Only a detected falling edge triggers a frame. A drdy_n held low never retriggers; it must be seen high again first.
- IDLE state:
  - sclk=1, rfs_n=1.
  - On a detected drdy_n falling edge with enable=1 → FRAME. On that same clk edge rfs_n goes 0, the divider clears and the bit counter clears.
  - Edges detected while enable=0 are dropped, not queued.
- FRAME state:
  - The divider counts 0..CLK_DIV-1; at terminal count sclk toggles and the divider wraps.
  - On each clk edge that drives sclk 1→0, sdata_in is shifted into the LSB of the shift register (shift left) and the bit counter increments.
  - Falling edge k (k=1..WORD_WIDTH) occurs (2k-1)*CLK_DIV clks after rfs_n falls.
  - On the sclk 0→1 toggle after the WORD_WIDTH-th falling edge, which is 2*WORD_WIDTH*CLK_DIV clks after rfs_n fell, that same clk edge does all of the following:
    - rfs_n→1;
    - sample←shift register;
    - sample_valid→1;
    - state→IDLE.
  - drdy_n edges during FRAME are ignored; the edge detector still tracks the level.
  - enable falling mid-frame does not abort; the frame completes normally.
- Latency: drdy_n falling to rfs_n low is 3 clks (2 sync + 1 detect/register). rfs_n low to sample_valid high is 2*WORD_WIDTH*CLK_DIV clks.
- Output handshake:
  - sample and sample_valid hold until accepted; an accept clears sample_valid on the next edge.
  - Frame completes while sample_valid=1 and there is no accept on that edge: sample is overwritten, sample_valid stays 1, overrun pulses high for 1 clk.
  - Frame completes on the same edge as an accept: the new sample is loaded, sample_valid stays 1, no overrun.
- Divider width is $clog2(CLK_DIV). The bit counter width is $clog2(WORD_WIDTH+1).

Test Plan:
- CLK_DIV=4, enable=1, one drdy_n low pulse, ADC model drives 16'hA5C3 MSB first on sclk rises; ready=1.
  - rfs_n low 3 clks after the pulse, 16 sclk falls at 4,12,…,124 clks.
  - sample=16'hA5C3, valid for exactly 1 clk at 128 clks after rfs_n fell.
- sample_ready=0, two frames 16'h1234 then 16'hFFFF.
  - After frame 1: valid=1, sample=16'h1234.
  - After frame 2: sample=16'hFFFF, valid=1, overrun high exactly 1 clk.
- Second frame completes on the exact clk that ready is asserted.
  - sample=new word, valid stays 1, overrun stays 0.
- rst asserted at bit 8 of a frame.
  - sclk=1, rfs_n=1, valid=0, sample=0 immediately.
  - After release, the next drdy_n frame captures 16'h0F0F correctly.
- enable=0 with a drdy_n pulse: no rfs_n activity.
- enable dropped at bit 5 of an active frame: the frame completes and valid asserts.
- drdy_n held low for 500 clks: exactly one frame.
- drdy_n pulse arriving mid-frame: ignored, no second frame.
